// File: rtl/approx_wallace_product_accumulator.sv
// Block accumulator for approximate Wallace tree products with a valid/ready result port.
// Define APPROX_ACC_SAT_EN to saturate on overflow instead of wrapping.
module approx_wallace_product_accumulator #(
  parameter int ACC_W     = 24,
  parameter int BLOCK_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      prod_i,
  input  logic             prod_valid_i,
  output logic             prod_ready_o,
  input  logic             clear_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic [7:0]       count_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] BLEN = 8'(BLOCK_LEN);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [7:0]       cnt_inc;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;

  assign prod_ready_o = (state_q != DONE) & ~clear_i;
  assign accept       = prod_valid_i & prod_ready_o;
  assign cnt_inc      = cnt_q + 8'd1;
  assign sum          = {1'b0, acc_q}
                      + {{(ACC_W-15){1'b0}}, prod_i};

`ifdef APPROX_ACC_SAT_EN
  assign acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}}
                              : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d   = acc_nxt;
            cnt_d   = cnt_inc;
            ovf_d   = ovf_q | sum[ACC_W];
            state_d = (cnt_inc == BLEN) ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (acc_ready_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_o       = acc_q;
  assign acc_valid_o = (state_q == DONE);
  assign count_o     = cnt_q;
  assign ovf_o       = ovf_q;

endmodule
